// File: rtl/i2c_mini_pkg.sv
// Shared types and constants for the compact I2C master: FSM states,
// quarter-phase encodings and SDA drive levels.
package i2c_mini_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    RW    = 3'd3,
    ACK_A = 3'd4,
    DATA  = 3'd5,
    ACK_D = 3'd6,
    STOP  = 3'd7
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Values for sda_oe: open-drain, so a 0 bit pulls low and a 1 bit releases.
  localparam logic DRIVE_LOW = 1'b1;
  localparam logic RELEASE   = 1'b0;

  function automatic logic bit_to_oe(input logic b);
    return b ? RELEASE : DRIVE_LOW;
  endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period timebase: one-cycle tick every CLK_DIV clocks while enabled,
// plus the 2-bit quarter phase within the current bit slot.
module i2c_qtick_gen
  import i2c_mini_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // clr realigns both the divider and the phase to the start of a slot.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (en) begin
      if (tick) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_mini_master.sv
// Single-master sequencer for the compact I2C frame:
// START, address, R/W, ACK, data, ACK, STOP.
module i2c_mini_master
  import i2c_mini_pkg::*;
#(
  parameter int ADDR_BITS = 4,
  parameter int BITS      = 6,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 rw,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [BITS-1:0]      wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 ack_err,
  output logic [BITS-1:0]      rdata,
  output logic                 scl_out,
  input  logic                 sda_in,
  output logic                 sda_out,
  output logic                 sda_oe,
  output logic [2:0]           state_dbg
);

  localparam int MAXB  = (ADDR_BITS > BITS) ? ADDR_BITS : BITS;
  localparam int CNT_W = $clog2(MAXB + 1);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     bit_cnt;
  logic [ADDR_BITS-1:0] addr_sr;
  logic [BITS-1:0]      data_sr;
  logic                 rw_r;
  logic                 tick;
  logic [1:0]           phase;
  logic                 accept;
  logic                 slot_end;
  logic                 sample;

  // Handshake: start is taken only while idle and not in the done cycle;
  // busy then stays high until the one-cycle done pulse, at which point
  // ack_err and rdata are valid (ack_err holds until the next accepted start).
  assign accept   = (state == IDLE) && start && !done;
  assign busy     = (state != IDLE);
  assign slot_end = tick && (phase == Q3);
  assign sample   = tick && (phase == Q2);
  assign sda_out  = 1'b0;
  assign state_dbg = state;

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (busy),
    .tick  (tick),
    .phase (phase)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = START;
      START: if (slot_end) state_nx = ADDR;
      ADDR:  if (slot_end && bit_cnt == '0) state_nx = RW;
      RW:    if (slot_end) state_nx = ACK_A;
      ACK_A: if (slot_end) state_nx = ack_err ? STOP : DATA;
      DATA:  if (slot_end && bit_cnt == '0) state_nx = ACK_D;
      ACK_D: if (slot_end) state_nx = STOP;
      STOP:  if (slot_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus levels decode from registered state/phase; SCL is high in Q2/Q3.
  always_comb begin
    scl_out = 1'b1;
    sda_oe  = RELEASE;
    case (state)
      IDLE: begin
        scl_out = 1'b1;
        sda_oe  = RELEASE;
      end
      START: begin
        scl_out = (phase != Q3);
        sda_oe  = (phase == Q0) ? RELEASE : DRIVE_LOW;
      end
      ADDR: begin
        scl_out = phase[1];
        sda_oe  = bit_to_oe(addr_sr[ADDR_BITS-1]);
      end
      RW: begin
        scl_out = phase[1];
        sda_oe  = bit_to_oe(rw_r);
      end
      DATA: begin
        scl_out = phase[1];
        sda_oe  = rw_r ? RELEASE : bit_to_oe(data_sr[BITS-1]);
      end
      STOP: begin
        scl_out = (phase != Q0);
        sda_oe  = (phase == Q0 || phase == Q1) ? DRIVE_LOW : RELEASE;
      end
      default: begin
        // ACK_A and ACK_D: master releases SDA (a read ends with NACK).
        scl_out = phase[1];
        sda_oe  = RELEASE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      addr_sr <= '0;
      data_sr <= '0;
      rw_r    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nx;
      done  <= (state == STOP) && slot_end;
      if (accept) begin
        rw_r    <= rw;
        addr_sr <= addr;
        data_sr <= wdata;
        ack_err <= 1'b0;
      end
      // A read only ever sets ack_err at ACK_A, so !ack_err means acknowledged.
      if ((state == STOP) && slot_end && rw_r && !ack_err) rdata <= data_sr;
      case (state)
        START: if (slot_end) bit_cnt <= CNT_W'(ADDR_BITS - 1);
        ADDR: begin
          if (slot_end) begin
            addr_sr <= addr_sr << 1;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ACK_A: begin
          if (sample && sda_in) ack_err <= 1'b1;
          if (slot_end) bit_cnt <= CNT_W'(BITS - 1);
        end
        DATA: begin
          if (rw_r && sample) data_sr <= {data_sr[BITS-2:0], sda_in};
          if (slot_end) begin
            bit_cnt <= bit_cnt - 1'b1;
            if (!rw_r) data_sr <= data_sr << 1;
          end
        end
        ACK_D: if (sample && sda_in && !rw_r) ack_err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_mini_master.sv
// Bench for i2c_mini_master: two instances (CLK_DIV 4 and 2), a bus-level
// slave model at address 0010, and a done-driven scoreboard.
module tb_i2c_mini_master;

  localparam logic [3:0] SLV_ADDR = 4'b0010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT wiring ----------------
  logic       start_v [2];
  logic       rw_v    [2];
  logic [3:0] addr_v  [2];
  logic [5:0] wdata_v [2];

  logic       busy_0, done_0, ack_err_0, scl_0, sda_out_0, sda_oe_0, sda_0;
  logic       busy_1, done_1, ack_err_1, scl_1, sda_out_1, sda_oe_1, sda_1;
  logic [5:0] rdata_0, rdata_1;
  logic [2:0] st_0, st_1;
  logic       pull [2];

  assign sda_0 = !(sda_oe_0 || pull[0]);
  assign sda_1 = !(sda_oe_1 || pull[1]);

  i2c_mini_master #(.ADDR_BITS(4), .BITS(6), .CLK_DIV(4)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .rw(rw_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .busy(busy_0), .done(done_0), .ack_err(ack_err_0),
    .rdata(rdata_0), .scl_out(scl_0), .sda_in(sda_0), .sda_out(sda_out_0),
    .sda_oe(sda_oe_0), .state_dbg(st_0)
  );

  i2c_mini_master #(.ADDR_BITS(4), .BITS(6), .CLK_DIV(2)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .rw(rw_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .busy(busy_1), .done(done_1), .ack_err(ack_err_1),
    .rdata(rdata_1), .scl_out(scl_1), .sda_in(sda_1), .sda_out(sda_out_1),
    .sda_oe(sda_oe_1), .state_dbg(st_1)
  );

  wire [1:0] busy_v = {busy_1, busy_0};
  wire [1:0] done_v = {done_1, done_0};
  wire [1:0] ack_v  = {ack_err_1, ack_err_0};
  wire [1:0] scl_v  = {scl_1, scl_0};
  wire [1:0] sda_v  = {sda_1, sda_0};
  logic [5:0] rdata_v [2];
  always_comb begin
    rdata_v[0] = rdata_0;
    rdata_v[1] = rdata_1;
  end

  // ---------------- bench slave (sampled bus, one per DUT) ----------------
  int         rise      [2] = '{0, 0};
  int         last_rise [2] = '{0, 0};
  int         starts    [2] = '{0, 0};
  int         stops     [2] = '{0, 0};
  logic       active    [2] = '{1'b0, 1'b0};
  logic       rw_s      [2] = '{1'b0, 1'b0};
  logic       ackd_s    [2] = '{1'b0, 1'b0};
  logic       p_scl     [2] = '{1'b1, 1'b1};
  logic       p_sda     [2] = '{1'b1, 1'b1};
  logic [3:0] addr_s    [2] = '{4'd0, 4'd0};
  logic [5:0] wr_s      [2] = '{6'd0, 6'd0};
  logic [5:0] rd_word   [2] = '{6'b010011, 6'b111111};

  initial begin
    pull[0] = 1'b0;
    pull[1] = 1'b0;
  end

  always @(negedge clk) begin : slave_proc
    logic c_scl, c_sda;
    for (int g = 0; g < 2; g++) begin
      c_scl = scl_v[g];
      c_sda = sda_v[g];
      if (p_scl[g] && c_scl && p_sda[g] && !c_sda) begin
        starts[g]++; active[g] = 1'b1; rise[g] = 0; pull[g] = 1'b0;
      end else if (p_scl[g] && c_scl && !p_sda[g] && c_sda) begin
        stops[g]++; last_rise[g] = rise[g]; active[g] = 1'b0; pull[g] = 1'b0;
      end else if (active[g] && !p_scl[g] && c_scl) begin
        rise[g]++;
        if (rise[g] <= 4) addr_s[g] = {addr_s[g][2:0], c_sda};
        else if (rise[g] == 5) rw_s[g] = c_sda;
        else if (rise[g] >= 7 && rise[g] <= 12 && !rw_s[g]) wr_s[g] = {wr_s[g][4:0], c_sda};
        else if (rise[g] == 13) ackd_s[g] = c_sda;
      end else if (active[g] && p_scl[g] && !c_scl) begin
        pull[g] = 1'b0;
        if (addr_s[g] == SLV_ADDR) begin
          if (rise[g] == 5) pull[g] = 1'b1;
          else if (rw_s[g] && rise[g] >= 6 && rise[g] <= 11) pull[g] = !rd_word[g][11-rise[g]];
          else if (!rw_s[g] && rise[g] == 12) pull[g] = 1'b1;
        end
      end
      p_scl[g] = c_scl;
      p_sda[g] = c_sda;
    end
  end

  // ---------------- scoreboard ----------------
  // item = {inst, latency[9:0], ack_err, rdata[5:0]}
  logic [17:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc       [2] = '{0, 0};
  int acc_cnt       [2] = '{0, 0};
  int done_cyc      [2] = '{0, 0};
  int prev_done_cyc [2] = '{0, 0};
  int done_cnt      [2] = '{0, 0};
  logic busy_p      [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin : monitor_proc
    logic [17:0] exp_item, got_item;
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (busy_v[g] && !busy_p[g]) begin
        acc_cyc[g] = cyc;
        acc_cnt[g]++;
      end
      if (done_v[g]) begin
        done_cnt[g]++;
        prev_done_cyc[g] = done_cyc[g];
        done_cyc[g] = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done inst=%0d at cycle %0d", g, cyc);
        end else begin
          exp_item = exp_q.pop_front();
          got_item = {1'(g), 10'(cyc - acc_cyc[g]), ack_v[g], rdata_v[g]};
          if (got_item !== exp_item) begin
            errors++;
            $display("FAIL done_txn: got inst/lat/ack_err/rdata=%0d/%0d/%0b/%b, expected %0d/%0d/%0b/%b",
                     got_item[17], got_item[16:7], got_item[6], got_item[5:0],
                     exp_item[17], exp_item[16:7], exp_item[6], exp_item[5:0]);
          end
        end
      end
      busy_p[g] = busy_v[g];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_txn(input int g, input int lat, input logic ae, input logic [5:0] rd);
    exp_q.push_back({1'(g), 10'(lat), ae, rd});
  endtask

  task automatic issue(input int g, input logic r, input logic [3:0] a, input logic [5:0] d);
    @(negedge clk);
    rw_v[g] = r; addr_v[g] = a; wdata_v[g] = d; start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int target, input int budget, input string name);
    int k;
    k = 0;
    while (done_cnt[g] < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_cnt[g] < target) begin
      errors++;
      $display("FAIL %s_timeout: done count %0d, needed %0d within %0d cycles", name, done_cnt[g], target, budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, s0, p0, a0, k, lo, hi;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start_v[g] = 1'b0; rw_v[g] = 1'b0; addr_v[g] = 4'd0; wdata_v[g] = 6'd0;
    end
    repeat (3) @(negedge clk);
    chk("rst_scl", scl_0, 1);
    chk("rst_sda_oe", sda_oe_0, 0);
    chk("rst_sda_out", sda_out_0, 0);
    chk("rst_busy", busy_0, 0);
    chk("rst_done", done_0, 0);
    chk("rst_ack_err", ack_err_0, 0);
    chk("rst_rdata", rdata_0, 0);
    chk("rst_state", st_0, 0);
    rst = 1'b0;

    // Reset while in DATA of a write: abort with no done.
    issue(0, 1'b0, SLV_ADDR, 6'b110011);
    repeat (130) @(negedge clk);
    chk("abort_in_data_state", st_0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_scl", scl_0, 1);
    chk("abort_sda_oe", sda_oe_0, 0);
    chk("abort_busy", busy_0, 0);
    n = done_cnt[0];
    repeat (300) @(negedge clk);
    chk("abort_no_done", done_cnt[0], n);

    // Write 101101 to the slave.
    s0 = starts[0]; p0 = stops[0]; n = done_cnt[0] + 1;
    expect_txn(0, 240, 1'b0, 6'b000000);
    issue(0, 1'b0, SLV_ADDR, 6'b101101);
    wait_done(0, n, 400, "write");
    chk("write_slave_data", wr_s[0], 6'b101101);
    chk("write_one_start", starts[0] - s0, 1);
    chk("write_one_stop", stops[0] - p0, 1);
    chk("write_scl_rises", last_rise[0], 14);

    // Read 010011 from the slave; master NACKs the data.
    n = done_cnt[0] + 1;
    expect_txn(0, 240, 1'b0, 6'b010011);
    issue(0, 1'b1, SLV_ADDR, 6'b000000);
    wait_done(0, n, 400, "read");
    chk("read_master_nack", ackd_s[0], 1);
    chk("read_rdata_held", rdata_0, 6'b010011);

    // Write to an absent slave: address NACK, no data slots.
    n = done_cnt[0] + 1;
    expect_txn(0, 128, 1'b1, 6'b010011);
    issue(0, 1'b0, 4'b0111, 6'b111000);
    wait_done(0, n, 400, "nack");
    chk("nack_scl_rises", last_rise[0], 7);
    repeat (5) @(negedge clk);
    chk("nack_ack_err_held", ack_err_0, 1);

    // start held high for 300 cycles: two back-to-back writes.
    n = done_cnt[0] + 2; a0 = acc_cnt[0];
    expect_txn(0, 240, 1'b0, 6'b010011);
    expect_txn(0, 240, 1'b0, 6'b010011);
    @(negedge clk);
    rw_v[0] = 1'b0; addr_v[0] = SLV_ADDR; wdata_v[0] = 6'b011010; start_v[0] = 1'b1;
    repeat (300) @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, n, 600, "held");
    chk("held_accept_gap", acc_cyc[0] - prev_done_cyc[0], 2);
    chk("held_slave_data", wr_s[0], 6'b011010);
    repeat (300) @(negedge clk);
    chk("held_accept_count", acc_cnt[0] - a0, 2);

    // CLK_DIV=2 instance: read 111111 and check the SCL period.
    n = done_cnt[1] + 1;
    expect_txn(1, 120, 1'b0, 6'b111111);
    issue(1, 1'b1, SLV_ADDR, 6'b000000);
    k = 0;
    while (rise[1] < 7 && k < 200) begin @(negedge clk); k++; end
    while (scl_1 !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    lo = 0;
    while (scl_1 === 1'b0 && lo < 50) begin @(negedge clk); lo++; end
    hi = 0;
    while (scl_1 === 1'b1 && hi < 50) begin @(negedge clk); hi++; end
    chk("div2_scl_low_cycles", lo, 4);
    chk("div2_scl_high_cycles", hi, 4);
    wait_done(1, n, 300, "div2_read");

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_mini_master.md
Name: i2c_mini_master

Overview:
- Single-master I2C transaction sequencer for the team's compact I2C protocol: START, 4-bit slave address, R/W bit, slave ACK, BITS data bits (MSB first), data ACK, STOP.
- Drives on-chip or board-level 6-bit I2C slaves (e.g. our slave at address 4'b0010) from a simple start/done handshake.
- Used for loopback self-test and for configuring downstream slaves.

Parameters:
- ADDR_BITS, 4, slave address width.
- BITS, 6, data payload width.
- CLK_DIV, 4, clk cycles per SCL quarter-period (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only while busy=0.
- rw  input  1  0=write, 1=read; captured with start.
- addr  input  ADDR_BITS  target address; captured with start.
- wdata  input  BITS  write payload; captured with start.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse at transaction end.
- ack_err  output  1  NACK seen in the last transaction; valid with done, held until next start.
- rdata  output  BITS  read payload; updated at done for reads only.
- scl_out  output  1  SCL, push-pull (single master).
- sda_in  input  1  SDA line value.
- sda_out  output  1  constant 0 (open-drain).
- sda_oe  output  1  1 = pull SDA low, 0 = release (line high).

Behaviour:
- Reset values: scl_out=1, sda_oe=0, sda_out=0, busy=0, done=0, ack_err=0, rdata=0; state=IDLE, divider cleared. Reset mid-transaction aborts immediately with no STOP generated.
- Quarter tick: asserted for one cycle every CLK_DIV clk cycles while busy; the divider restarts on start acceptance.
- Bit slot = 4 quarters:
  - Q0: SCL low, SDA updated.
  - Q1: SCL low.
  - Q2: SCL high.
  - Q3: SCL high.
  - SDA sampled at the tick ending Q2.
- States: IDLE -> START -> ADDR -> RW -> ACK_A -> DATA -> ACK_D -> STOP -> IDLE.
  - IDLE: start=1 latches rw, addr, wdata; clears ack_err; sets busy; -> START. start while busy is ignored.
  - START (4 quarters): SDA released with SCL high; SDA low while SCL high; SCL low.
  - ADDR: ADDR_BITS slots, addr MSB first.
  - RW: one slot carrying rw.
  - ACK_A: SDA released; sample. sda_in=1 sets ack_err and goes -> STOP, skipping DATA.
  - DATA, write: BITS slots driving wdata MSB first.
  - DATA, read: SDA released; shift in sda_in MSB first.
  - ACK_D, write: SDA released; sample; 1 sets ack_err.
  - ACK_D, read: master NACKs (releases SDA) to end the read.
  - STOP (4 quarters): SDA low, SCL low; SCL high; SDA released; idle.
  - Return to IDLE: done=1 for one cycle, busy=0; rdata loaded from the shift register if rw=1 and ACK_A was acknowledged.
- Bit-to-SDA mapping: bit 0 -> sda_oe=1; bit 1 -> sda_oe=0.
- Latency from the start-accept edge to done, successful transfer: (8 + 4*(ADDR_BITS+BITS+3))*CLK_DIV cycles (240 at defaults).
  - Address NACK: (8 + 4*(ADDR_BITS+2))*CLK_DIV cycles.
- Bit counter is ceil(log2(max(ADDR_BITS,BITS)+1)) wide and reloads at each field.
- start in the same cycle as done is ignored; a new request is accepted from the following cycle.

Decomposition:
- Package i2c_mini_pkg:
  - state enum (IDLE, START, ADDR, RW, ACK_A, DATA, ACK_D, STOP).
  - quarter-phase constants Q0..Q3.
  - SDA drive constants DRIVE_LOW/RELEASE.
- Sub-module i2c_qtick_gen: CLK_DIV divider with clear input; outputs the quarter tick and a 2-bit phase.

Test Plan:
- Reset during DATA of a write (rst high 1 cycle) -> next cycle scl_out=1, sda_oe=0, busy=0, done never pulses; new start then completes normally.
- Write addr=4'b0010, wdata=6'b101101 to bench slave at 0010 -> slave captures 101101; done at cycle 240; ack_err=0; exactly one START and one STOP seen on the bus.
- Read addr=0010, slave returns 6'b010011 -> rdata=010011 at done; master releases SDA at ACK_D (NACK); ack_err=0.
- Write to addr=4'b0111 (no slave) -> ack_err=1; no data slots; done at (8+24)*4=128 cycles; rdata unchanged.
- start held high for 300 cycles -> exactly one transaction at a time; second accepted the cycle after done; busy low only during the done cycle.
- CLK_DIV=2, read of 6'b111111 -> SCL high/low each 4 cycles; done at 120 cycles; rdata=111111.
